alu_result_stage: RTL
=====================

Name: alu_result_stage

Overview:
Registered output stage directly downstream of the 16-bit bitwise/arithmetic units (xor, and, or, add). It captures each unit result with a valid/ready handshake, derives status flags at capture time, and buffers up to two results in a skid buffer so the upstream handshake never stalls combinationally on out_ready. It also keeps a wrapping count of delivered results for debug readout.

Parameters:
WIDTH, 16, datapath width of result and flag derivation
CNT_W, 16, width of delivered-result counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream result valid
in_ready  output  1  stage can accept; registered, depends only on buffer occupancy
in_result  input  WIDTH  result from selected unit
in_op  input  2  producing unit: 00 and, 01 or, 10 xor, 11 add
in_carry  input  1  carry-out from adder; meaningful only when in_op=11
out_valid  output  1  buffered result available
out_ready  input  1  downstream accepts
out_result  output  WIDTH  head result
out_op  output  2  head op code
out_zero  output  1  head result == 0
out_neg  output  1  head result MSB
out_parity  output  1  XOR-reduction of head result (1 = odd number of ones)
out_carry  output  1  in_carry if in_op=11 at capture, else 0
out_count  output  CNT_W  number of completed output handshakes, wraps

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-low on rst_n.
- Reset (async assert, sync release on clk): occupancy EMPTY, out_valid=0, in_ready=1, out_result=0, out_op=0, all flags 0, out_count=0. The skid entry is cleared.
- Input handshake: in_fire = in_valid & in_ready. Output handshake: out_fire = out_valid & out_ready.
- Storage: head entry (drives out_*) and skid entry. Each entry holds result, op, zero, neg, parity, carry.
- Flags are computed from in_result/in_op/in_carry at capture and stored with the entry. They are never recomputed at the output.
- Occupancy FSM: EMPTY, ONE, TWO.
  - EMPTY: in_fire -> load head, go ONE.
  - ONE, in_fire & !out_fire -> load skid, go TWO.
  - ONE, in_fire & out_fire -> load head, stay ONE.
  - ONE, !in_fire & out_fire -> go EMPTY.
  - TWO: in_ready=0, so no in_fire is possible. out_fire -> head<=skid, go ONE.
- out_valid = (state != EMPTY). in_ready = (state != TWO). Both are driven from state registers, with no combinational path from out_ready.
- Latency: a result accepted on cycle N appears on out_* at cycle N+1 when the buffer was EMPTY or ONE with out_fire that cycle.
- Ordering: strict FIFO; the skid entry is always older than any subsequent input.
- Head stability: head contents and out_valid hold stable while out_valid=1 and out_ready=0.
- Counter: out_count increments by 1 on each out_fire, modulo 2^CNT_W (0xFFFF -> 0x0000). It is unaffected by in_fire.
- Ignored inputs: in_valid while in_ready=0 is ignored (the upstream must hold it). in_carry is ignored unless in_op=11.
- Reset mid-operation: both entries are discarded immediately, and pending results are lost. After release the stage accepts on the first cycle.

Test Plan:
- Reset with in_valid=1 and in_result=0xFFFF held -> during reset out_valid=0, in_ready=1, out_count=0. No capture occurs until rst_n rises.
- Single xor result: in_result=0x0000, in_op=10, in_carry=1, out_ready=1 -> next cycle out_result=0x0000, zero=1, neg=0, parity=0, carry=0. out_count=1 after the handshake.
- Add result 0x8001, in_op=11, in_carry=1 -> out_neg=1, out_parity=0, out_carry=1, out_zero=0.
- Backpressure: out_ready=0, feed 0x0001, 0x0003, 0x0007 back-to-back -> in_ready drops after the second accept and 0x0007 is held off. Then raise out_ready -> outputs arrive 0x0001, 0x0003, 0x0007 in order with parity 1, 0, 1.
- Simultaneous in_fire and out_fire in ONE for 10 cycles with incrementing data -> state stays ONE, one result per cycle, no loss or duplication.
- Counter wrap: preload by 65535 handshakes (or force) then one more out_fire -> out_count=0x0000. Assert rst_n low mid-TWO -> out_valid=0 immediately.

Source files
------------

// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: upstream capture and downstream delivery signals of the ALU result stage.
interface alu_result_stage_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_result;
  logic [1:0] in_op;
  logic in_carry;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_result;
  logic [1:0] out_op;
  logic out_zero;
  logic out_neg;
  logic out_parity;
  logic out_carry;
  logic [CNT_W-1:0] out_count;
  modport slave (
    input  in_valid, in_result, in_op, in_carry, out_ready,
    output in_ready, out_valid, out_result, out_op, out_zero, out_neg, out_parity, out_carry, out_count
  );
  modport master (
    output in_valid, in_result, in_op, in_carry, out_ready,
    input  in_ready, out_valid, out_result, out_op, out_zero, out_neg, out_parity, out_carry, out_count
  );
endinterface

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered two-entry skid stage capturing ALU results with status flags and a delivered-result counter.
module alu_result_stage #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  alu_result_stage_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [1:0] op;
    logic zero;
    logic neg;
    logic parity;
    logic carry;
  } entry_t;
  state_t state, state_nxt;
  entry_t head, skid, new_entry;
  logic [CNT_W-1:0] count;
  logic in_fire, out_fire;
  logic head_ld_in, head_ld_skid, skid_ld;
  assign bus.in_ready = state != TWO;
  assign bus.out_valid = state != EMPTY;
  assign in_fire = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;
  // Flags are frozen at capture so the output side never recomputes them.
  assign new_entry = '{
    result: bus.in_result,
    op:     bus.in_op,
    zero:   bus.in_result == '0,
    neg:    bus.in_result[WIDTH-1],
    parity: ^bus.in_result,
    carry:  (bus.in_op == 2'b11) & bus.in_carry
  };
  always_comb begin
    state_nxt = state;
    head_ld_in = 1'b0;
    head_ld_skid = 1'b0;
    skid_ld = 1'b0;
    unique case (state)
      EMPTY: begin
        head_ld_in = in_fire;
        state_nxt = in_fire ? ONE : EMPTY;
      end
      ONE: begin
        head_ld_in = in_fire & out_fire;
        skid_ld = in_fire & ~out_fire;
        state_nxt = (in_fire & ~out_fire) ? TWO : (~in_fire & out_fire) ? EMPTY : ONE;
      end
      TWO: begin
        head_ld_skid = out_fire;
        state_nxt = out_fire ? ONE : TWO;
      end
      default: state_nxt = EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      head <= '0;
      skid <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (head_ld_in) head <= new_entry;
      else if (head_ld_skid) head <= skid;
      if (skid_ld) skid <= new_entry;
      if (out_fire) count <= count + 1'b1;
    end
  end
  assign bus.out_result = head.result;
  assign bus.out_op = head.op;
  assign bus.out_zero = head.zero;
  assign bus.out_neg = head.neg;
  assign bus.out_parity = head.parity;
  assign bus.out_carry = head.carry;
  assign bus.out_count = count;
endmodule
